// File: rtl/z80_blk_pkg.sv
// Shared definitions for the Z80 block-instruction engine: FSM encodings,
// T-state costs, flag bit positions and small arithmetic helpers.
package z80_blk_pkg;

  // FSM encodings, kept as plain constants for the legacy sequencer code
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_EXT  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    BLK_IDLE = ST_IDLE,
    BLK_RD   = ST_RD,
    BLK_WR   = ST_WR,
    BLK_EXT  = ST_EXT,
    BLK_DONE = ST_DONE
  } blk_state_t;

  // T-states per iteration: final/single iteration vs one that repeats
  localparam int TS_ITER   = 16;
  localparam int TS_REPEAT = 21;

  // Flag bit positions, identical to the core's FLAG_*_BIT definitions
  localparam int FLAG_C_BIT  = 0;
  localparam int FLAG_N_BIT  = 1;
  localparam int FLAG_PV_BIT = 2;
  localparam int FLAG_3_BIT  = 3;
  localparam int FLAG_H_BIT  = 4;
  localparam int FLAG_5_BIT  = 5;
  localparam int FLAG_Z_BIT  = 6;
  localparam int FLAG_S_BIT  = 7;

  // Borrow out of bit 3 into bit 4 for an 8-bit subtract a - b
  function automatic logic half_borrow(input logic [7:0] a, input logic [7:0] b);
    return (a[3:0] < b[3:0]);
  endfunction

endpackage

// File: rtl/z80_block_op_engine_flags.sv
// Combinational flag computation for one block-instruction iteration.
// CP family: S/Z/H from A - byte, N set; LD family: H and N cleared.
// Both: P/V reports whether the counter is still non-zero after the step.
module z80_blk_flags
  import z80_blk_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              op_cp,
  input  logic [7:0]        a,
  input  logic [7:0]        data,
  input  logic [7:0]        f_in,
  input  logic [ADDR_W-1:0] bc_new,
  output logic [7:0]        f
);

  logic [7:0] diff_s;

  // Merge computed flags over the incoming ones; untouched bits pass through
  always_comb begin
    diff_s = a - data;
    f      = f_in;
    f[FLAG_PV_BIT] = (bc_new != {ADDR_W{1'b0}});
    if (op_cp) begin
      f[FLAG_S_BIT] = diff_s[7];
      f[FLAG_Z_BIT] = (diff_s == 8'h00);
      f[FLAG_H_BIT] = half_borrow(a, data);
      f[FLAG_N_BIT] = 1'b1;
    end else begin
      f[FLAG_H_BIT] = 1'b0;
      f[FLAG_N_BIT] = 1'b0;
    end
  end

endmodule

// File: rtl/z80_block_op_engine.sv
// Sequential executor for LDI/LDD/LDIR/LDDR/CPI/CPD/CPIR/CPDR.
// Runs each iteration over a req/ack bus, updates HL/DE/BC and flags,
// accumulates T-states and yields repeat forms on interrupt or burst limit.
module z80_block_op_engine
  import z80_blk_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MAX_BURST = 16,
  parameter int TSTATE_W  = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                op_cp,
  input  logic                op_dec,
  input  logic                op_rep,
  input  logic                irq_pend,
  input  logic [7:0]          a_in,
  input  logic [7:0]          f_in,
  input  logic [ADDR_W-1:0]   bc_in,
  input  logic [ADDR_W-1:0]   hl_in,
  input  logic [ADDR_W-1:0]   de_in,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [7:0]          mem_wdata,
  input  logic [7:0]          mem_rdata,
  input  logic                mem_ack,
  output logic                busy,
  output logic                done,
  output logic [7:0]          f_out,
  output logic [ADDR_W-1:0]   bc_out,
  output logic [ADDR_W-1:0]   hl_out,
  output logic [ADDR_W-1:0]   de_out,
  output logic                ip_rewind,
  output logic [TSTATE_W-1:0] tstates
);

  localparam int ITER_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [ITER_W-1:0]   ITER_LIMIT = ITER_W'(MAX_BURST);
  localparam logic [ADDR_W-1:0]   ADDR_ONE   = ADDR_W'(1);
  localparam logic [TSTATE_W:0]   TS_ITER_X  = (TSTATE_W + 1)'(TS_ITER);
  localparam logic [TSTATE_W:0]   TS_REP_X   = (TSTATE_W + 1)'(TS_REPEAT);

  logic [2:0]          state_r;
  logic                op_cp_r, op_dec_r, op_rep_r;
  logic [7:0]          a_r, f_r, byte_r;
  logic [ADDR_W-1:0]   bc_r, hl_r, de_r;
  logic [ITER_W-1:0]   iter_r;
  logic [TSTATE_W-1:0] tstates_r;
  logic                ip_rewind_r, busy_r, done_r;
  logic                mem_req_r, mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [7:0]          mem_wdata_r;

  logic [ADDR_W-1:0]   bc_new_s, hl_new_s, de_new_s;
  logic [7:0]          f_new_s;
  logic                rep_cont_s, yield_s;
  logic [ITER_W-1:0]   iter_next_s;
  logic [TSTATE_W:0]   ts_sum_s;
  logic [TSTATE_W-1:0] ts_next_s;

  z80_blk_flags #(.ADDR_W(ADDR_W)) u_flags (
    .op_cp  (op_cp_r),
    .a      (a_r),
    .data   (byte_r),
    .f_in   (f_r),
    .bc_new (bc_new_s),
    .f      (f_new_s)
  );

  // End-of-iteration arithmetic: pointer/counter steps, loop decision, T-state sum
  always_comb begin
    bc_new_s    = bc_r - ADDR_ONE;
    hl_new_s    = op_dec_r ? (hl_r - ADDR_ONE) : (hl_r + ADDR_ONE);
    de_new_s    = op_dec_r ? (de_r - ADDR_ONE) : (de_r + ADDR_ONE);
    iter_next_s = iter_r + ITER_W'(1);
    rep_cont_s  = op_rep_r && (bc_new_s != {ADDR_W{1'b0}}) &&
                  !(op_cp_r && f_new_s[FLAG_Z_BIT]);
    yield_s     = rep_cont_s && (irq_pend || (iter_next_s == ITER_LIMIT));
    ts_sum_s    = {1'b0, tstates_r} + (rep_cont_s ? TS_REP_X : TS_ITER_X);
    if (ts_sum_s[TSTATE_W]) begin
      ts_next_s = {TSTATE_W{1'b1}};
    end else begin
      ts_next_s = ts_sum_s[TSTATE_W-1:0];
    end
  end

  // Control FSM, bus master and architectural register updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      op_cp_r     <= 1'b0;
      op_dec_r    <= 1'b0;
      op_rep_r    <= 1'b0;
      a_r         <= 8'h00;
      f_r         <= 8'h00;
      byte_r      <= 8'h00;
      bc_r        <= {ADDR_W{1'b0}};
      hl_r        <= {ADDR_W{1'b0}};
      de_r        <= {ADDR_W{1'b0}};
      iter_r      <= {ITER_W{1'b0}};
      tstates_r   <= {TSTATE_W{1'b0}};
      ip_rewind_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= 8'h00;
    end else begin
      case (state_r)
        // DONE behaves like IDLE so a start may coincide with done
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            op_cp_r     <= op_cp;
            op_dec_r    <= op_dec;
            op_rep_r    <= op_rep;
            a_r         <= a_in;
            f_r         <= f_in;
            bc_r        <= bc_in;
            hl_r        <= hl_in;
            de_r        <= de_in;
            iter_r      <= {ITER_W{1'b0}};
            tstates_r   <= {TSTATE_W{1'b0}};
            ip_rewind_r <= 1'b0;
            busy_r      <= 1'b1;
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= hl_in;
            state_r     <= ST_RD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD: begin
          if (mem_ack) begin
            byte_r <= mem_rdata;
            if (op_cp_r) begin
              mem_req_r <= 1'b0;
              state_r   <= ST_EXT;
            end else begin
              mem_we_r    <= 1'b1;
              mem_addr_r  <= de_r;
              mem_wdata_r <= mem_rdata;
              state_r     <= ST_WR;
            end
          end
        end
        ST_WR: begin
          if (mem_ack) begin
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            state_r   <= ST_EXT;
          end
        end
        ST_EXT: begin
          bc_r      <= bc_new_s;
          hl_r      <= hl_new_s;
          de_r      <= op_cp_r ? de_r : de_new_s;
          f_r       <= f_new_s;
          tstates_r <= ts_next_s;
          iter_r    <= iter_next_s;
          if (rep_cont_s && !yield_s) begin
            mem_req_r  <= 1'b1;
            mem_we_r   <= 1'b0;
            mem_addr_r <= hl_new_s;
            state_r    <= ST_RD;
          end else begin
            ip_rewind_r <= yield_s;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= ST_DONE;
          end
        end
        default: begin
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign f_out     = f_r;
  assign bc_out    = bc_r;
  assign hl_out    = hl_r;
  assign de_out    = de_r;
  assign ip_rewind = ip_rewind_r;
  assign tstates   = tstates_r;

endmodule

// File: tb/tb_z80_block_op_engine.sv
// Scoreboard bench for z80_block_op_engine (MAX_BURST=4). Scenarios push
// expected results and writes; a bus responder and a done monitor check them.
module tb_z80_block_op_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, op_cp = 1'b0, op_dec = 1'b0, op_rep = 1'b0, irq_pend = 1'b0;
  logic [7:0]  a_in = 8'h00, f_in = 8'h00;
  logic [15:0] bc_in = 16'h0000, hl_in = 16'h0000, de_in = 16'h0000;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata = 8'h00;
  logic        busy, done, ip_rewind;
  logic [7:0]  f_out;
  logic [15:0] bc_out, hl_out, de_out;
  logic [19:0] tstates;

  z80_block_op_engine #(.ADDR_W(16), .MAX_BURST(4), .TSTATE_W(20)) dut (
    .clk(clk), .reset(reset), .start(start), .op_cp(op_cp), .op_dec(op_dec),
    .op_rep(op_rep), .irq_pend(irq_pend), .a_in(a_in), .f_in(f_in),
    .bc_in(bc_in), .hl_in(hl_in), .de_in(de_in), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done),
    .f_out(f_out), .bc_out(bc_out), .hl_out(hl_out), .de_out(de_out),
    .ip_rewind(ip_rewind), .tstates(tstates)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  f;
    logic [15:0] bc, hl, de;
    logic        rw;
    logic [19:0] ts;
  } res_t;
  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  res_t exp_q[$];
  wr_t  wr_q[$];
  logic [7:0] mem [0:65535];
  int   checks = 0;
  int   errors = 0;
  int   lat_max = 0;
  logic withhold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] f, input logic [15:0] bc, hl, de,
                          input logic rw, input logic [19:0] ts);
    res_t e;
    e.f = f; e.bc = bc; e.hl = hl; e.de = de; e.rw = rw; e.ts = ts;
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input logic [15:0] addr, input logic [7:0] data);
    wr_t w;
    w.addr = addr; w.data = data;
    wr_q.push_back(w);
  endtask

  // Bus responder: random latency, checks request stability and write targets
  initial begin : responder
    int          cnt;
    logic        waiting;
    logic [15:0] s_addr;
    logic        s_we;
    logic [7:0]  s_wdata;
    wr_t         w;
    waiting = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        waiting = 1'b0;
      end
      if (reset || !mem_req) begin
        waiting = 1'b0;
      end else if (!withhold) begin
        if (!waiting) begin
          waiting = 1'b1;
          cnt = $urandom_range(lat_max, 0);
          s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
        end else begin
          check("bus_addr_stable", {16'h0, mem_addr}, {16'h0, s_addr});
          check("bus_we_stable", {31'h0, mem_we}, {31'h0, s_we});
          if (s_we) check("bus_wdata_stable", {24'h0, mem_wdata}, {24'h0, s_wdata});
        end
        if (cnt == 0) begin
          if (mem_we) begin
            if (wr_q.size() == 0) begin
              check("unexpected_write_addr", {16'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
              w = wr_q.pop_front();
              check("write_addr", {16'h0, mem_addr}, {16'h0, w.addr});
              check("write_data", {24'h0, mem_wdata}, {24'h0, w.data});
            end
            mem[mem_addr] = mem_wdata;
          end else begin
            mem_rdata = mem[mem_addr];
          end
          mem_ack = 1'b1;
          waiting = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Done monitor: pops the scoreboard and compares every result output
  always @(negedge clk) begin : monitor
    res_t e;
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("f_out", {24'h0, f_out}, {24'h0, e.f});
        check("bc_out", {16'h0, bc_out}, {16'h0, e.bc});
        check("hl_out", {16'h0, hl_out}, {16'h0, e.hl});
        check("de_out", {16'h0, de_out}, {16'h0, e.de});
        check("ip_rewind", {31'h0, ip_rewind}, {31'h0, e.rw});
        check("tstates", {12'h0, tstates}, {12'h0, e.ts});
        check("busy_at_done", {31'h0, busy}, 32'h0);
      end
    end
  end

  // Issue one instruction and wait (bounded) for its done pulse
  task automatic run_op(input logic cp, dec, rep, input logic [7:0] a, f,
                        input logic [15:0] bc, hl, de, input logic irq, poke);
    bit seen;
    op_cp = cp; op_dec = dec; op_rep = rep; a_in = a; f_in = f;
    bc_in = bc; hl_in = hl; de_in = de;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (irq) irq_pend = 1'b1;
    if (poke) begin
      @(negedge clk);
      @(negedge clk);
      hl_in = 16'hBEEF; bc_in = 16'h0001; de_in = 16'hDEAD;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check("done_timeout", 32'h0, 32'h1);
    irq_pend = 1'b0;
  endtask

  // CPD A=40, (1000)=41, BC=2, F=29: S=1 Z=0 H=1 V=1 N=1, 5/3/C kept -> BF
  task automatic scen_cpd();
    mem[16'h1000] = 8'h41;
    push_exp(8'hBF, 16'h0001, 16'h0FFF, 16'h5555, 1'b0, 20'd16);
    run_op(1'b1, 1'b1, 1'b0, 8'h40, 8'h29, 16'h0002, 16'h1000, 16'h5555, 1'b0, 1'b0);
  endtask

  // LDIR BC=3 from 2000 to 3000, F=FF: final V=0, H=N=0 -> E9, 21+21+16
  task automatic scen_ldir(input logic poke);
    mem[16'h2000] = 8'h11; mem[16'h2001] = 8'h22; mem[16'h2002] = 8'h33;
    push_wr(16'h3000, 8'h11); push_wr(16'h3001, 8'h22); push_wr(16'h3002, 8'h33);
    push_exp(8'hE9, 16'h0000, 16'h2003, 16'h3003, 1'b0, 20'd58);
    run_op(1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 16'h0003, 16'h2000, 16'h3000, 1'b0, poke);
  endtask

  // CPIR A=22 over 11 22 33, BC=5: match on 2nd byte -> Z=1 V=1 N=1 = 46, 21+16
  task automatic scen_cpir();
    mem[16'h2100] = 8'h11; mem[16'h2101] = 8'h22; mem[16'h2102] = 8'h33;
    push_exp(8'h46, 16'h0003, 16'h2102, 16'h1234, 1'b0, 20'd37);
    run_op(1'b1, 1'b0, 1'b1, 8'h22, 8'h00, 16'h0005, 16'h2100, 16'h1234, 1'b0, 1'b0);
  endtask

  // LDDR BC=0 with burst limit 4: four writes, yield, BC=FFFC, 4*21 T-states
  task automatic scen_lddr();
    mem[16'h4000] = 8'hA0; mem[16'h4001] = 8'hA1; mem[16'h4002] = 8'hA2; mem[16'h4003] = 8'hA3;
    push_wr(16'h5003, 8'hA3); push_wr(16'h5002, 8'hA2);
    push_wr(16'h5001, 8'hA1); push_wr(16'h5000, 8'hA0);
    push_exp(8'hED, 16'hFFFC, 16'h3FFF, 16'h4FFF, 1'b1, 20'd84);
    run_op(1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 16'h0000, 16'h4003, 16'h5003, 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_mem_req", {31'h0, mem_req}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_done", {31'h0, done}, 32'h0);
    check("idle_tstates", {12'h0, tstates}, 32'h0);
    check("idle_hl", {16'h0, hl_out}, 32'h0);
    check("idle_f", {24'h0, f_out}, 32'h0);
    check("idle_rewind", {31'h0, ip_rewind}, 32'h0);

    // zero-wait bus, back-to-back starts coincide with done
    scen_cpd();
    scen_ldir(1'b0);
    scen_cpir();
    scen_lddr();

    // LDI (non-repeat) with BC=5: exactly one iteration, F=D7 -> C5
    push_wr(16'h6000, 8'h11);
    push_exp(8'hC5, 16'h0004, 16'h2001, 16'h6001, 1'b0, 20'd16);
    run_op(1'b0, 1'b0, 1'b0, 8'h00, 8'hD7, 16'h0005, 16'h2000, 16'h6000, 1'b0, 1'b0);

    // LDIR with interrupt raised during iteration 1: yields after one write
    push_wr(16'h7000, 8'h11);
    push_exp(8'h04, 16'h0002, 16'h2001, 16'h7001, 1'b1, 20'd21);
    run_op(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 16'h0003, 16'h2000, 16'h7000, 1'b1, 1'b0);

    // reset while the read is outstanding: request must drop at once
    withhold = 1'b1;
    op_cp = 1'b1; op_dec = 1'b0; op_rep = 1'b0; hl_in = 16'h2000; bc_in = 16'h0002;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_req", {31'h0, mem_req}, 32'h1);
    check("pre_reset_busy", {31'h0, busy}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_req", {31'h0, mem_req}, 32'h0);
    check("async_reset_busy", {31'h0, busy}, 32'h0);
    check("async_reset_ts", {12'h0, tstates}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    withhold = 1'b0;
    @(negedge clk);
    scen_cpd();

    // random ack latency: identical results, start while busy is ignored
    lat_max = 5;
    scen_ldir(1'b1);
    scen_cpir();
    scen_lddr();
    scen_cpd();

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    check("writes_drained", wr_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
